// File: rtl/fu_arith_rsv_station.sv
// fu_arith_rsv_station: data-capturing reservation station for the integer arithmetic FU, oldest-ready issue.
// Define RS_ISSUE_BYPASS_EN to let a ready dispatch skip the station when nothing else is eligible.
module fu_arith_rsv_station #(
  parameter int DEPTH = 4,
  parameter int PRN_W = 7,
  parameter int ID_W  = 6,
  parameter int NWAKE = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [31:0]                   disp_inst,
  input  logic [ID_W-1:0]               disp_inst_id,
  input  logic [PRN_W-1:0]              disp_out_prn,
  input  logic [1:0][PRN_W-1:0]         disp_src_prn,
  input  logic [1:0]                    disp_src_rdy,
  input  logic [1:0][63:0]              disp_src_data,
  input  logic [NWAKE-1:0]              wk_valid,
  input  logic [NWAKE-1:0][PRN_W-1:0]   wk_prn,
  input  logic [NWAKE-1:0][63:0]        wk_data,
  input  logic                          fu_ready,
  output logic                          iss_valid,
  output logic [31:0]                   iss_inst,
  output logic [1:0][63:0]              iss_op,
  output logic [PRN_W-1:0]              iss_out_prn,
  output logic [ID_W-1:0]               iss_inst_id,
  output logic [$clog2(DEPTH):0]        occupancy
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  typedef struct packed {
    logic [31:0]          inst;
    logic [ID_W-1:0]      id;
    logic [PRN_W-1:0]     out;
    logic [1:0][PRN_W-1:0] prn;
    logic [1:0]           rdy;
    logic [1:0][63:0]     data;
  } ent_t;
  ent_t                       ent_q [DEPTH];
  ent_t                       ent_d [DEPTH];
  ent_t                       disp_e;
  logic [DEPTH-1:0]           val_q, val_d, elig, grant;
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  logic [CW-1:0]              occ_q, occ_d;
  logic [IW-1:0]              sel_idx, free_idx;
  logic                       disp_fire, iss_fire, alloc, byp;
  logic                       iss_valid_q, iss_valid_d;
  logic [31:0]                iss_inst_q, iss_inst_d;
  logic [1:0][63:0]           iss_op_q, iss_op_d;
  logic [PRN_W-1:0]           iss_out_q, iss_out_d;
  logic [ID_W-1:0]            iss_id_q, iss_id_d;
  // Lowest-index bus wins when several buses carry the same PRN.
  function automatic ent_t wake(input ent_t e);
    wake = e;
    for (int o = 0; o < 2; o++)
      for (int b = NWAKE - 1; b >= 0; b--)
        if (!e.rdy[o] && wk_valid[b] && wk_prn[b] == e.prn[o]) begin
          wake.rdy[o]  = 1'b1;
          wake.data[o] = wk_data[b];
        end
  endfunction
  assign disp_ready = (occ_q < CW'(DEPTH)) && !flush;
  always_comb begin
    disp_e    = wake({disp_inst, disp_inst_id, disp_out_prn, disp_src_prn, disp_src_rdy, disp_src_data});
    elig      = '0;
    grant     = '0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = 0; i < DEPTH; i++) elig[i] = val_q[i] && (&ent_q[i].rdy);
    // age_q[i][j] set means entry i was dispatched before entry j.
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = elig[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && elig[j] && !age_q[i][j]) grant[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) if (grant[i]) sel_idx = IW'(i);
    for (int i = DEPTH - 1; i >= 0; i--) if (!val_q[i]) free_idx = IW'(i);
    disp_fire = disp_valid && disp_ready;
    iss_fire  = fu_ready && (|elig) && !flush;
`ifdef RS_ISSUE_BYPASS_EN
    byp       = disp_fire && (&disp_e.rdy) && !(|elig) && fu_ready;
`else
    byp       = 1'b0;
`endif
    alloc     = disp_fire && !byp;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = wake(ent_q[i]);
    if (alloc) ent_d[free_idx] = disp_e;
    val_d = val_q;
    if (iss_fire) val_d[sel_idx] = 1'b0;
    if (alloc) val_d[free_idx] = 1'b1;
    if (flush) val_d = '0;
    age_d = age_q;
    if (alloc)
      for (int j = 0; j < DEPTH; j++) begin
        age_d[j][free_idx] = 1'b1;
        age_d[free_idx][j] = 1'b0;
      end
    occ_d       = flush ? '0 : occ_q + CW'(alloc) - CW'(iss_fire);
    iss_valid_d = iss_fire || byp;
    iss_inst_d  = iss_fire ? ent_q[sel_idx].inst : byp ? disp_e.inst : iss_inst_q;
    iss_op_d    = iss_fire ? ent_q[sel_idx].data : byp ? disp_e.data : iss_op_q;
    iss_out_d   = iss_fire ? ent_q[sel_idx].out  : byp ? disp_e.out  : iss_out_q;
    iss_id_d    = iss_fire ? ent_q[sel_idx].id   : byp ? disp_e.id   : iss_id_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      val_q       <= '0;
      age_q       <= '0;
      occ_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_inst_q  <= '0;
      iss_op_q    <= '0;
      iss_out_q   <= '0;
      iss_id_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      val_q       <= val_d;
      age_q       <= age_d;
      occ_q       <= occ_d;
      iss_valid_q <= iss_valid_d;
      iss_inst_q  <= iss_inst_d;
      iss_op_q    <= iss_op_d;
      iss_out_q   <= iss_out_d;
      iss_id_q    <= iss_id_d;
    end
  end
  assign iss_valid   = iss_valid_q;
  assign iss_inst    = iss_inst_q;
  assign iss_op      = iss_op_q;
  assign iss_out_prn = iss_out_q;
  assign iss_inst_id = iss_id_q;
  assign occupancy   = occ_q;
endmodule

// File: tb/tb_fu_arith_rsv_station.sv
// tb_fu_arith_rsv_station: queue-based reference model checked every cycle, plus directed literal expectations.
module tb_fu_arith_rsv_station;
  localparam int DEPTH = 4, PRN_W = 7, ID_W = 6, NWAKE = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush, disp_valid, disp_ready, fu_ready, iss_valid;
  logic [31:0] disp_inst, iss_inst;
  logic [ID_W-1:0] disp_inst_id, iss_inst_id;
  logic [PRN_W-1:0] disp_out_prn, iss_out_prn;
  logic [1:0][PRN_W-1:0] disp_src_prn;
  logic [1:0] disp_src_rdy;
  logic [1:0][63:0] disp_src_data, iss_op;
  logic [NWAKE-1:0] wk_valid;
  logic [NWAKE-1:0][PRN_W-1:0] wk_prn;
  logic [NWAKE-1:0][63:0] wk_data;
  logic [$clog2(DEPTH):0] occupancy;
  int n_chk = 0, n_err = 0;
  bit chk_en = 0;

  fu_arith_rsv_station #(.DEPTH(DEPTH), .PRN_W(PRN_W), .ID_W(ID_W), .NWAKE(NWAKE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_inst(disp_inst), .disp_inst_id(disp_inst_id), .disp_out_prn(disp_out_prn),
    .disp_src_prn(disp_src_prn), .disp_src_rdy(disp_src_rdy), .disp_src_data(disp_src_data),
    .wk_valid(wk_valid), .wk_prn(wk_prn), .wk_data(wk_data), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_inst(iss_inst), .iss_op(iss_op), .iss_out_prn(iss_out_prn),
    .iss_inst_id(iss_inst_id), .occupancy(occupancy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [5:0] id;
    logic [6:0] out;
    logic [1:0][6:0] prn;
    logic [1:0] rdy;
    logic [1:0][63:0] data;
  } ment_t;
  ment_t mq[$];
  ment_t m_ne;
  int m_sel;
  bit m_acc, m_byp;
  logic ev = 1'b0;
  logic [31:0] e_inst = '0;
  logic [5:0] e_id = '0;
  logic [6:0] e_out = '0;
  logic [1:0][63:0] e_op = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ment_t mwake(input ment_t e);
    ment_t r;
    bit hit;
    r = e;
    for (int o = 0; o < 2; o++) begin
      hit = 0;
      for (int b = 0; b < NWAKE; b++)
        if (!hit && !e.rdy[o] && wk_valid[b] && wk_prn[b] == e.prn[o]) begin
          hit = 1;
          r.rdy[o] = 1'b1;
          r.data[o] = wk_data[b];
        end
    end
    return r;
  endfunction

  task automatic load(input ment_t x);
    ev = 1'b1;
    e_inst = x.inst;
    e_id = x.id;
    e_out = x.out;
    e_op = x.data;
  endtask

  // Queue order is dispatch order, so the first ready element is the oldest ready op.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      ev = 0; e_inst = 0; e_id = 0; e_out = 0; e_op = 0;
    end else if (flush) begin
      mq.delete();
      ev = 0;
    end else begin
      m_sel = -1;
      for (int i = 0; i < mq.size(); i++) if (m_sel < 0 && (&mq[i].rdy)) m_sel = i;
      m_ne = mwake({disp_inst, disp_inst_id, disp_out_prn, disp_src_prn, disp_src_rdy, disp_src_data});
      m_acc = disp_valid && (mq.size() < DEPTH);
      m_byp = 0;
`ifdef RS_ISSUE_BYPASS_EN
      m_byp = m_acc && (&m_ne.rdy) && (m_sel < 0) && fu_ready;
`endif
      ev = 0;
      if (fu_ready && m_sel >= 0) begin
        load(mq[m_sel]);
        mq.delete(m_sel);
      end else if (m_byp) load(m_ne);
      foreach (mq[i]) mq[i] = mwake(mq[i]);
      if (m_acc && !m_byp) mq.push_back(m_ne);
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("iss_valid", iss_valid, ev);
    chk("iss_inst", iss_inst, e_inst);
    chk("iss_inst_id", iss_inst_id, e_id);
    chk("iss_out_prn", iss_out_prn, e_out);
    chk("iss_op0", iss_op[0], e_op[0]);
    chk("iss_op1", iss_op[1], e_op[1]);
    chk("occupancy", occupancy, mq.size());
    chk("disp_ready", disp_ready, (mq.size() < DEPTH) && !flush);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int id, input logic [1:0] rdy, input int p0, input int p1,
                      input logic [63:0] d0, input logic [63:0] d1);
    disp_valid = 1'b1;
    disp_inst = 32'h0B00_0000 | 32'(id);
    disp_inst_id = 6'(id);
    disp_out_prn = 7'(id + 64);
    disp_src_prn[0] = 7'(p0);
    disp_src_prn[1] = 7'(p1);
    disp_src_rdy = rdy;
    disp_src_data[0] = d0;
    disp_src_data[1] = d1;
  endtask

  initial begin
    flush = 0; disp_valid = 0; fu_ready = 0; disp_inst = 0; disp_inst_id = 0; disp_out_prn = 0;
    disp_src_prn = '0; disp_src_rdy = 0; disp_src_data = '0; wk_valid = 0; wk_prn = '0; wk_data = '0;
    #1 rst_n = 0;
    #1 chk_en = 1;
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_iss_op0", iss_op[0], 0);
    chk("rst_iss_id", iss_inst_id, 0);
    repeat (2) tick();
    rst_n = 1;
    // single ready ADD
    fu_ready = 1;
    disp(3, 2'b11, 1, 2, 64'd5, 64'd7);
    tick();
    disp_valid = 0;
`ifdef RS_ISSUE_BYPASS_EN
    chk("t1_byp_valid", iss_valid, 1);
    chk("t1_byp_op0", iss_op[0], 5);
    chk("t1_byp_occ", occupancy, 0);
`else
    chk("t1_occ1", occupancy, 1);
    chk("t1_not_yet", iss_valid, 0);
    tick();
    chk("t1_valid", iss_valid, 1);
    chk("t1_op0", iss_op[0], 5);
    chk("t1_id", iss_inst_id, 3);
    chk("t1_occ0", occupancy, 0);
`endif
    tick();
    chk("t1_pulse_end", iss_valid, 0);
    // younger ready op overtakes an op waiting on PRN 9
    disp(1, 2'b01, 4, 9, 64'd1, 64'd0);
    tick();
    disp(2, 2'b11, 5, 6, 64'd2, 64'd3);
    tick();
    disp_valid = 0;
    wk_valid = 2'b01; wk_prn[0] = 7'd9; wk_data[0] = 64'h77;
`ifdef RS_ISSUE_BYPASS_EN
    chk("t2_byp_id", iss_inst_id, 2);
    chk("t2_byp_valid", iss_valid, 1);
`else
    chk("t2_idle", iss_valid, 0);
`endif
    tick();
    wk_valid = 0;
`ifdef RS_ISSUE_BYPASS_EN
    chk("t2_gap", iss_valid, 0);
`else
    chk("t2_id2_valid", iss_valid, 1);
    chk("t2_id2", iss_inst_id, 2);
    chk("t2_id2_op0", iss_op[0], 2);
`endif
    tick();
    chk("t2_id1_valid", iss_valid, 1);
    chk("t2_id1", iss_inst_id, 1);
    chk("t2_id1_op1", iss_op[1], 64'h77);
    chk("t2_id1_op0", iss_op[0], 1);
    tick();
    // fill, then drain in dispatch order with a same-cycle dispatch and issue
    fu_ready = 0;
    for (int k = 0; k < 4; k++) begin
      disp(10 + k, 2'b11, 0, 0, 64'(100 + k), 64'(200 + k));
      tick();
    end
    disp(14, 2'b11, 0, 0, 64'd114, 64'd214);
    chk("t3_full_occ", occupancy, 4);
    chk("t3_full_rdy", disp_ready, 0);
    fu_ready = 1;
    tick();
    chk("t3_first", iss_inst_id, 10);
    chk("t3_occ3", occupancy, 3);
    disp(15, 2'b11, 0, 0, 64'd115, 64'd215);
    tick();
    disp_valid = 0;
    chk("t3_second", iss_inst_id, 11);
    chk("t3_occ_same", occupancy, 3);
    tick();
    chk("t3_third", iss_inst_id, 12);
    tick();
    chk("t3_fourth", iss_inst_id, 13);
    chk("t3_fourth_op1", iss_op[1], 203);
    tick();
    chk("t3_fifth", iss_inst_id, 15);
    chk("t3_empty", occupancy, 0);
    tick();
    chk("t3_drained", iss_valid, 0);
    // same-cycle wakeup at dispatch, with a non-matching bus alongside
    disp(20, 2'b10, 12, 0, 64'd0, 64'd9);
    wk_valid = 2'b11; wk_prn[0] = 7'd13; wk_data[0] = 64'hCD; wk_prn[1] = 7'd12; wk_data[1] = 64'hAB;
    tick();
    disp_valid = 0; wk_valid = 0;
`ifndef RS_ISSUE_BYPASS_EN
    chk("t4_wait", iss_valid, 0);
    tick();
`endif
    chk("t4_valid", iss_valid, 1);
    chk("t4_id", iss_inst_id, 20);
    chk("t4_op0", iss_op[0], 64'hAB);
    chk("t4_op1", iss_op[1], 9);
    tick();
    // two buses hit the same PRN: bus 0 wins
    disp(21, 2'b01, 0, 20, 64'd4, 64'd0);
    tick();
    disp_valid = 0;
    wk_valid = 2'b11; wk_prn[0] = 7'd20; wk_prn[1] = 7'd20; wk_data[0] = 64'h111; wk_data[1] = 64'h222;
    tick();
    wk_valid = 0;
    tick();
    chk("t4b_valid", iss_valid, 1);
    chk("t4b_id", iss_inst_id, 21);
    chk("t4b_op1", iss_op[1], 64'h111);
    tick();
    // flush with a concurrent dispatch
    fu_ready = 0;
    for (int k = 0; k < 3; k++) begin
      disp(30 + k, 2'b11, 0, 0, 64'(30 + k), 64'd1);
      tick();
    end
    chk("t5_occ3", occupancy, 3);
    flush = 1; fu_ready = 1;
    disp(33, 2'b11, 0, 0, 64'd33, 64'd1);
    tick();
    flush = 0; disp_valid = 0;
    chk("t5_occ0", occupancy, 0);
    chk("t5_no_issue", iss_valid, 0);
    repeat (3) tick();
    chk("t5_still_empty", occupancy, 0);
    chk("t5_never_issued", iss_valid, 0);
    // asynchronous reset mid-operation
    fu_ready = 0;
    disp(40, 2'b11, 0, 0, 64'd40, 64'd41);
    tick();
    disp(41, 2'b11, 0, 0, 64'd42, 64'd43);
    tick();
    disp_valid = 0;
    chk("t6_occ2", occupancy, 2);
    rst_n = 0;
    #1;
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_op0", iss_op[0], 0);
    tick();
    rst_n = 1; fu_ready = 1;
    repeat (3) tick();
    chk("t6_lost", iss_valid, 0);
    chk("t6_occ_after", occupancy, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fu_arith_rsv_station.md
Name: fu_arith_rsv_station

Overview:
- Data-capturing reservation station directly upstream of the integer arithmetic functional unit (ADD/ADDS/SUB/SUBS/CMP).
- Accepts dispatched micro-ops from rename/dispatch and holds them until both source operands are available.
- Captures operand values from the writeback wakeup buses.
- Issues the oldest ready entry to the FU whenever the FU signals ready.

Parameters:
DEPTH, 4, number of entries (power of 2, 2..16)
PRN_W, 7, physical register number width
ID_W, 6, instruction id width
NWAKE, 2, number of wakeup/writeback buses snooped

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all entries
disp_valid  input  1  dispatch request
disp_ready  output  1  free entry available (combinational from registered occupancy and flush)
disp_inst  input  32  raw instruction word
disp_inst_id  input  ID_W  instruction id
disp_out_prn  input  PRN_W  destination PRN
disp_src_prn  input  2xPRN_W  source PRNs, op0/op1
disp_src_rdy  input  2  source already available
disp_src_data  input  2x64  source values, valid where disp_src_rdy=1 (immediate-only op1: rdy=1, data=0)
wk_valid  input  NWAKE  wakeup bus valid
wk_prn  input  NWAKExPRN_W  wakeup PRN
wk_data  input  NWAKEx64  wakeup value
fu_ready  input  1  FU can accept an instruction this cycle
iss_valid  output  1  registered; drives FU inst_valid
iss_inst  output  32  drives FU inst
iss_op  output  2x64  drives FU op[0], op[1]
iss_out_prn  output  PRN_W  drives FU out_prn
iss_inst_id  output  ID_W  drives FU inst_id
occupancy  output  $clog2(DEPTH)+1  registered count of valid entries

Behaviour:
- Reset (rst_n low, async): all entry valid bits clear; iss_valid=0; iss_inst, iss_op, iss_out_prn, iss_inst_id, occupancy all 0. Leaving reset mid-operation loses all entries; no partial state survives.
- Dispatch:
  - Accepted when disp_valid && disp_ready; disp_ready = (occupancy < DEPTH) && !flush.
  - Writes the lowest-index free entry and stamps it youngest in the DEPTHxDEPTH age matrix.
- Wakeup:
  - Each cycle, every waiting operand of every valid entry compares against all wk buses; a match with wk_valid captures wk_data and sets rdy.
  - A dispatching operand with rdy=0 that matches a wakeup in the same cycle captures it (no lost wakeup).
  - Multiple buses matching one PRN: lowest bus index wins (identical data expected).
- Select:
  - An entry is eligible when valid and both operands rdy, evaluated on registered state.
  - The oldest eligible entry is selected per the age matrix.
- Issue:
  - If fu_ready && an eligible entry exists, the issue registers load the selected entry and the entry is freed at the same edge; iss_valid=1 next cycle.
  - Otherwise iss_valid=0 next cycle, and iss_* data holds its last value.
  - iss_valid is one cycle per issue; back-to-back issues are allowed every cycle.
  - iss_op carries the wakeup value if the selected entry's operand is being woken in the select cycle? No: the entry must already be eligible on registered state.
- Latency:
  - Dispatch with both rdy at cycle T → eligible T+1 → iss_valid in T+2.
  - Wakeup at cycle W → iss_valid earliest W+2.
- Simultaneous events:
  - Issue free plus dispatch in the same cycle: occupancy is unchanged.
  - Full (occupancy=DEPTH): disp_ready=0. An issue in that cycle does not raise disp_ready until the next cycle.
  - Empty: no issue.
- Flush: clears all valid bits and forces occupancy=0 and iss_valid=0 at the next edge. Dispatch in a flush cycle is dropped. Flush overrides issue.

Optional Feature:
RS_ISSUE_BYPASS_EN: when defined, a dispatch arriving under all of the following conditions skips entry allocation and loads the issue registers directly, giving iss_valid at T+1:
- both operands rdy (including same-cycle wakeup capture);
- no eligible entry in the station;
- fu_ready=1.
Undefined: minimum dispatch-to-issue latency is 2 cycles and every op occupies an entry.

Test Plan:
- Reset, then dispatch ADD id=3 with rdy=11, data op0=5, fu_ready=1 → iss_valid pulse at T+2 with iss_op[0]=5, iss_inst_id=3, occupancy 1→0.
- Dispatch id=1 (op1 PRN 9 not rdy) then id=2 (rdy); wk_prn=9, data=0x77 at cycle 4 → id=2 issues first; id=1 issues with iss_op[1]=0x77 no earlier than cycle 6.
- Fill 4 entries with fu_ready=0 → disp_ready=0, occupancy=4. Raise fu_ready → issue order matches dispatch order 0,1,2,3, one per cycle.
- Dispatch with op0 PRN 12 not rdy in the same cycle as wk_prn=12, data=0xAB → entry captures 0xAB and issues at T+2.
- Occupancy 3, assert flush with disp_valid=1 → next cycle occupancy=0, iss_valid=0, no later issue of the flushed ids.
- With RS_ISSUE_BYPASS_EN, empty station, fu_ready=1, ready dispatch at T → iss_valid at T+1, occupancy stays 0.
